fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage for the RV32I core: owns the program counter, a synchronous-read instruction memory with a load/write port, and a registered output with a valid/ready handshake to decode. It adds stall back-pressure, branch/jump redirect with flush, and fault reporting for misaligned and out-of-range fetches, none of which the single-cycle datapath had. It sits between reset/branch resolution and the decode stage.

## Interface
- XLEN, 32, data and PC width.
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words; power of two, ≥ 2.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- ADDR_W (localparam), $clog2(IMEM_DEPTH), word-index width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- redirect_valid  in  1  taken branch/jump; overrides everything except reset.
- redirect_pc  in  XLEN  redirect target.
- out_ready  in  1  decode accepts the output this cycle.
- out_valid  out  1  out_instr/out_pc/out_fault hold a fetched instruction.
- out_instr  out  32  fetched instruction word.
- out_pc  out  XLEN  address of out_instr.
- out_fault  out  2  fault code, from the package.
- imem_we  in  1  instruction memory write enable (program load).
- imem_waddr  in  ADDR_W  write word index.
- imem_wdata  in  32  write data.

## Operation
- State: pc_q (next fetch address), FSM {RUN, HALT}, output register {out_valid, out_instr, out_pc, out_fault}.
- Reset: pc_q=RESET_PC, state=RUN, out_valid=0, out_instr=NOP (32'h0000_0013), out_pc=0, out_fault=FAULT_NONE. Memory contents are not reset.
- Issue condition: state==RUN && !redirect_valid && (!out_valid || out_ready).
- On issue with pc_q in range and aligned: output register <= {1, imem[pc_q[ADDR_W+1:2]], pc_q, FAULT_NONE}; pc_q <= pc_q+4, wrapping modulo 2^XLEN.
- Out of range (pc_q[XLEN-1:ADDR_W+2] != 0): output <= {1, NOP, pc_q, FAULT_RANGE}; pc_q unchanged; state -> HALT.
- Misaligned (pc_q[1:0] != 0): output <= {1, NOP, pc_q, FAULT_MISALIGN}; state -> HALT. Misalign is checked before range.
- No issue and out_valid && out_ready: out_valid <= 0. No issue and !out_ready: output register holds all fields.
- HALT: no issue. Leaves only via redirect or reset.
- Redirect (any state): pc_q <= redirect_pc, out_valid <= 0 (flushes the held instruction whether or not out_ready), state -> RUN.
- Priority: reset > redirect > issue > hold.
- Write port: when imem_we, imem[imem_waddr] <= imem_wdata. A same-cycle read of the same index returns the old data (read-first).

## Timing
- Memory read is synchronous. The read register is the output register, so fetch latency is 1 cycle from issue.
- First valid output appears in the cycle after the first clock edge following reset deassertion, with out_pc=RESET_PC.
- Redirect sampled at edge t: bubble in cycle t..t+1; target instruction valid after edge t+1. Penalty is one cycle.
- Steady state with out_ready=1: one instruction per cycle, out_pc incrementing by 4.
- out_ready low: outputs stable. No instruction is skipped or duplicated across any number of stall cycles.
- Once raised, a fault output stays valid until accepted. After that out_valid=0 until redirect.

## Structure
- Package fetch_pkg holds: NOP_INSTR constant, fault code enum (FAULT_NONE=0, FAULT_MISALIGN=1, FAULT_RANGE=2), and the FSM state enum.
- Sub-module imem_sync is a 1R1W synchronous RAM, parametrised by depth and width, read-first, with a read enable tied to the issue condition.

## Test plan
- Reset with RESET_PC=0 and imem[0..3]={A,B,C,D}, out_ready=1 -> out_pc 0,4,8,12 on consecutive cycles with out_instr A,B,C,D.
- out_ready=0 for 3 cycles while out_pc=4 -> out_pc=4 and out_instr=B held all 3 cycles; after release, the next output is out_pc=8 (C).
- redirect_valid=1 with redirect_pc=0x20 while a stalled valid output is held -> out_valid=0 the next cycle, then out_pc=0x20 with instr imem[8].
- Redirect to 0x22 -> one output with out_fault=MISALIGN, instr NOP, out_pc=0x22; then out_valid=0 indefinitely until a redirect to 0x0.
- IMEM_DEPTH=256, run to pc=0x3FC -> word 255 is fetched normally, then out_pc=0x400 with out_fault=RANGE and HALT; reset mid-HALT -> restarts at RESET_PC.
- imem_we to index 5 in the same cycle as the fetch of 0x14 -> old word returned; a refetch after a redirect returns the new word.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and enums for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_MISALIGN = 2'd1,
        FAULT_RANGE    = 2'd2
    } fault_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/imem_sync.sv
// 1R1W synchronous RAM, read-first on address collision; read data holds when re is low.
module imem_sync #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, synchronous instruction memory, and a valid/ready output
// register with redirect/flush and misalign/range fault reporting.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN       = 32,
    parameter int               IMEM_DEPTH = 256,
    parameter logic [XLEN-1:0]  RESET_PC   = '0,
    localparam int              ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [31:0]       out_instr,
    output logic [XLEN-1:0]   out_pc,
    output logic [1:0]        out_fault,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [31:0]       imem_wdata
);

    state_t            r_state, w_state_next;
    logic [XLEN-1:0]   r_pc, w_pc_next;
    logic [XLEN-1:0]   r_out_pc, w_out_pc_next;
    logic              r_out_valid, w_out_valid_next;
    logic              r_nop, w_nop_next;
    fault_t            r_fault, w_fault_next;

    logic              w_issue;
    logic              w_misalign;
    logic              w_range;
    logic [31:0]       w_ram_rdata;

    assign w_issue    = (r_state == ST_RUN) && !redirect_valid && (!r_out_valid || out_ready);
    assign w_misalign = (r_pc[1:0] != 2'b00);
    assign w_range    = ((r_pc >> (ADDR_W + 2)) != '0);

    // The RAM read register doubles as the instruction half of the output register;
    // r_nop substitutes NOP after reset and on faults without needing a resettable RAM.
    imem_sync #(
        .DEPTH (IMEM_DEPTH),
        .WIDTH (32)
    ) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (imem_waddr),
        .wdata (imem_wdata),
        .re    (w_issue),
        .raddr (r_pc[ADDR_W+1:2]),
        .rdata (w_ram_rdata)
    );

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_out_pc_next    = r_out_pc;
        w_out_valid_next = r_out_valid;
        w_nop_next       = r_nop;
        w_fault_next     = r_fault;

        if (redirect_valid) begin
            w_pc_next        = redirect_pc;
            w_out_valid_next = 1'b0;
            w_state_next     = ST_RUN;
        end else if (w_issue) begin
            w_out_valid_next = 1'b1;
            w_out_pc_next    = r_pc;
            if (w_misalign) begin
                w_nop_next   = 1'b1;
                w_fault_next = FAULT_MISALIGN;
                w_state_next = ST_HALT;
            end else if (w_range) begin
                w_nop_next   = 1'b1;
                w_fault_next = FAULT_RANGE;
                w_state_next = ST_HALT;
            end else begin
                w_nop_next   = 1'b0;
                w_fault_next = FAULT_NONE;
                w_pc_next    = r_pc + XLEN'(4);
            end
        end else if (r_out_valid && out_ready) begin
            w_out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_out_pc    <= '0;
            r_out_valid <= 1'b0;
            r_nop       <= 1'b1;
            r_fault     <= FAULT_NONE;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_out_pc    <= w_out_pc_next;
            r_out_valid <= w_out_valid_next;
            r_nop       <= w_nop_next;
            r_fault     <= w_fault_next;
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_nop ? NOP_INSTR : w_ram_rdata;
    assign out_pc    = r_out_pc;
    assign out_fault = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against a behavioural fetch model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  out_fault;
    logic        imem_we = 1'b0;
    logic [7:0]  imem_waddr = '0;
    logic [31:0] imem_wdata = '0;

    int n_checks = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc;
    bit          m_halt;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_opc;
    logic [1:0]  m_fault;

    logic [31:0] prog [4] = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h0040_0213};

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN       (32),
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_fault      (out_fault),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata)
    );

    // One clock: advance the model with the inputs present at the edge, then settle.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_pc = 32'h0; m_halt = 0; m_valid = 0;
            m_instr = NOP_INSTR; m_opc = 32'h0; m_fault = 2'd0;
        end else if (redirect_valid) begin
            m_pc = redirect_pc; m_valid = 0; m_halt = 0;
        end else if (!m_halt && (!m_valid || out_ready)) begin
            m_valid = 1; m_opc = m_pc;
            if (m_pc % 4 != 0) begin
                m_instr = NOP_INSTR; m_fault = 2'd1; m_halt = 1;
            end else if (m_pc >= DEPTH * 4) begin
                m_instr = NOP_INSTR; m_fault = 2'd2; m_halt = 1;
            end else begin
                m_instr = m_mem[m_pc / 4]; m_fault = 2'd0; m_pc = m_pc + 4;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        if (imem_we) m_mem[imem_waddr] = imem_wdata;
        #1;
    endtask

    task automatic test_reset();
        logic [66:0] obs, exp;
        reset = 1; out_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            imem_we = 1; imem_waddr = 8'(i);
            imem_wdata = (i < 4) ? prog[i] : $urandom;
            step();
        end
        imem_we = 0;
        step();
        obs = {out_valid, out_instr, out_pc, out_fault};
        exp = {1'b0, NOP_INSTR, 32'h0, 2'd0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs, exp); end
        $display("reset: out_valid=%0b out_instr=%h", out_valid, out_instr);
    endtask

    task automatic test_stream();
        logic [66:0] obs, exp;
        reset = 0; out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            obs = {out_valid, out_instr, out_pc, out_fault};
            exp = {1'b1, prog[i], 32'(i * 4), 2'd0};
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL stream_%0d: got %h want %h", i, obs, exp); end
            $display("stream: pc=%h instr=%h", out_pc, out_instr);
        end
    endtask

    task automatic test_stall();
        logic [66:0] obs, exp;
        reset = 1; step(); reset = 0; out_ready = 1;
        step(); step();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            obs = {out_valid, out_instr, out_pc, out_fault};
            exp = {1'b1, prog[1], 32'h4, 2'd0};
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL stall_hold_%0d: got %h want %h", i, obs, exp); end
            $display("stall: pc=%h instr=%h", out_pc, out_instr);
        end
        out_ready = 1;
        step();
        obs = {out_valid, out_instr, out_pc, out_fault};
        exp = {1'b1, prog[2], 32'h8, 2'd0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL stall_release: got %h want %h", obs, exp); end
        $display("release: pc=%h instr=%h", out_pc, out_instr);
    endtask

    task automatic test_redirect();
        logic [66:0] obs, exp;
        out_ready = 0;
        redirect_valid = 1; redirect_pc = 32'h20;
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_flush: got %b want 0", out_valid); end
        redirect_valid = 0;
        step();
        obs = {out_valid, out_instr, out_pc, out_fault};
        exp = {1'b1, m_mem[8], 32'h20, 2'd0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL redirect_target: got %h want %h", obs, exp); end
        $display("redirect: pc=%h instr=%h", out_pc, out_instr);
        out_ready = 1;
    endtask

    task automatic test_misalign();
        logic [66:0] obs, exp;
        redirect_valid = 1; redirect_pc = 32'h22; out_ready = 0;
        step();
        redirect_valid = 0;
        step();
        exp = {1'b1, NOP_INSTR, 32'h22, 2'd1};
        for (int i = 0; i < 2; i++) begin
            obs = {out_valid, out_instr, out_pc, out_fault};
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL misalign_out_%0d: got %h want %h", i, obs, exp); end
            $display("misalign: pc=%h fault=%0d", out_pc, out_fault);
            step();
        end
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL misalign_halt_%0d: got %b want 0", i, out_valid); end
        end
        redirect_valid = 1; redirect_pc = 32'h0;
        step();
        redirect_valid = 0;
        step();
        obs = {out_valid, out_instr, out_pc, out_fault};
        exp = {1'b1, prog[0], 32'h0, 2'd0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL misalign_recover: got %h want %h", obs, exp); end
        $display("recover: pc=%h instr=%h", out_pc, out_instr);
    endtask

    task automatic test_range();
        logic [66:0] obs, exp;
        out_ready = 1;
        redirect_valid = 1; redirect_pc = 32'h3F8;
        step();
        redirect_valid = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            obs = {out_valid, out_instr, out_pc, out_fault};
            if (i < 2) exp = {1'b1, m_mem[254 + i], 32'(32'h3F8 + 4 * i), 2'd0};
            else       exp = {1'b1, NOP_INSTR, 32'h400, 2'd2};
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL range_%0d: got %h want %h", i, obs, exp); end
            $display("range: pc=%h fault=%0d", out_pc, out_fault);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL range_halt_%0d: got %b want 0", i, out_valid); end
        end
        reset = 1; step(); reset = 0;
        step();
        obs = {out_valid, out_instr, out_pc, out_fault};
        exp = {1'b1, prog[0], 32'h0, 2'd0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL range_reset_restart: got %h want %h", obs, exp); end
        $display("restart: pc=%h instr=%h", out_pc, out_instr);
    endtask

    task automatic test_rw_collision();
        logic [66:0] obs, exp;
        logic [31:0] old_word;
        out_ready = 1;
        redirect_valid = 1; redirect_pc = 32'h10;
        step();
        redirect_valid = 0;
        step();
        old_word = m_mem[5];
        imem_we = 1; imem_waddr = 8'd5; imem_wdata = ~old_word;
        step();
        imem_we = 0;
        obs = {out_valid, out_instr, out_pc, out_fault};
        exp = {1'b1, old_word, 32'h14, 2'd0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL collision_old: got %h want %h", obs, exp); end
        $display("collision: pc=%h instr=%h", out_pc, out_instr);
        redirect_valid = 1; redirect_pc = 32'h14;
        step();
        redirect_valid = 0;
        step();
        obs = {out_valid, out_instr, out_pc, out_fault};
        exp = {1'b1, ~old_word, 32'h14, 2'd0};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL collision_new: got %h want %h", obs, exp); end
        $display("refetch: pc=%h instr=%h", out_pc, out_instr);
    endtask

    task automatic test_random();
        int sel;
        int errs = 0;
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 7)       redirect_pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            else if (sel == 7) redirect_pc = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            else if (sel == 8) redirect_pc = {$urandom_range(1, 1023), 10'h0} + 32'($urandom_range(0, 255) * 4);
            else               redirect_pc = 32'h3F0;
            imem_we = ($urandom_range(0, 4) == 0);
            imem_waddr = 8'($urandom_range(0, 255));
            imem_wdata = $urandom;
            step();
            n_checks++;
            if (out_valid !== m_valid ||
                (m_valid && (out_instr !== m_instr || out_pc !== m_opc || out_fault !== m_fault))) begin
                n_fail++; errs++;
                if (errs <= 10)
                    $display("FAIL random_cycle_%0d: got v=%b i=%h pc=%h f=%0d want v=%b i=%h pc=%h f=%0d",
                             c, out_valid, out_instr, out_pc, out_fault, m_valid, m_instr, m_opc, m_fault);
            end
            if (c % 50 == 0)
                $display("random cycle %0d: v=%b pc=%h f=%0d", c, out_valid, out_pc, out_fault);
        end
        reset = 0; redirect_valid = 0; imem_we = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misalign();
        test_range();
        test_rw_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
